mul32_shift_add: RTL and testbench

MUL32_SHIFT_ADD -- requirements
Module: mul32_shift_add

---
 rtl/mul_pkg.sv | 17 +
 rtl/carry_look_ahead.sv | 42 ++++
 rtl/mul32_shift_add.sv | 80 ++++++++
 tb/tb_mul32_shift_add.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/mul_pkg.sv
// Shared definitions for the radix-2 shift-and-add multiplier.
// Holds the controller state encoding and the operand/product widths.
package mul_pkg;

  localparam int OP_W   = 32;
  localparam int PROD_W = 64;

  // Value of cnt during the final of the 32 iterations.
  localparam logic [4:0] ITER_LAST = 5'd31;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/carry_look_ahead.sv
// 32-bit block carry-lookahead adder: 4-bit lookahead groups with the
// group carries chained from the least-significant group upward.
module carry_look_ahead
  import mul_pkg::*;
(
  input  logic [OP_W-1:0] a,
  input  logic [OP_W-1:0] b,
  input  logic            c0,
  output logic [OP_W-1:0] sum,
  output logic            c32
);

  logic [OP_W-1:0] g;
  logic [OP_W-1:0] p;
  logic [OP_W:0]   c;

  always_comb begin
    // NOTE: every variable gets a value before any branch or loop so that
    // this block stays purely combinational and never infers a latch.
    g = a & b;
    p = a ^ b;
    c = '0;
    c[0] = c0;
    for (int grp = 0; grp < OP_W / 4; grp++) begin
      int base;
      base = 4 * grp;
      c[base+1] = g[base] | (p[base] & c[base]);
      c[base+2] = g[base+1] | (p[base+1] & g[base])
                | (p[base+1] & p[base] & c[base]);
      c[base+3] = g[base+2] | (p[base+2] & g[base+1])
                | (p[base+2] & p[base+1] & g[base])
                | (p[base+2] & p[base+1] & p[base] & c[base]);
      c[base+4] = g[base+3] | (p[base+3] & g[base+2])
                | (p[base+3] & p[base+2] & g[base+1])
                | (p[base+3] & p[base+2] & p[base+1] & g[base])
                | (p[base+3] & p[base+2] & p[base+1] & p[base] & c[base]);
    end
    sum = p ^ c[OP_W-1:0];
    c32 = c[OP_W];
  end

endmodule

// File: rtl/mul32_shift_add.sv
// Sequential 32x32 unsigned multiplier: one shift-and-add iteration per
// cycle through a shared carry-lookahead adder, 32 cycles per product.
module mul32_shift_add
  import mul_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   multiplicand,
  input  logic [OP_W-1:0]   multiplier,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [PROD_W-1:0] product
);

  state_t          state;
  logic [OP_W-1:0] mcand;
  logic [OP_W-1:0] acc;
  logic [OP_W-1:0] mq;
  logic [4:0]      cnt;

  logic [OP_W-1:0] addend;
  logic [OP_W-1:0] sum;
  logic            c32;

  // The low multiplier bit selects whether this iteration adds mcand.
  assign addend = mq[0] ? mcand : '0;

  carry_look_ahead u_adder (
    .a   (acc),
    .b   (addend),
    .c0  (1'b0),
    .sum (sum),
    .c32 (c32)
  );

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values and the update order inside the block is moot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      mcand <= '0;
      acc   <= '0;
      mq    <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand <= multiplicand;
            mq    <= multiplier;
            acc   <= '0;
            cnt   <= '0;
            state <= RUN;
          end
        end
        RUN: begin
          // The adder carry becomes the new acc MSB; the sum LSB drops into mq.
          {acc, mq} <= {c32, sum, mq[OP_W-1:1]};
          cnt       <= cnt + 5'd1;
          if (cnt == ITER_LAST) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);
  assign product   = {acc, mq};

endmodule

// File: tb/tb_mul32_shift_add.sv
// Directed self-checking bench for mul32_shift_add: latency, exact products,
// backpressure, busy-input rejection and asynchronous reset mid-operation.
module tb_mul32_shift_add;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] product;

  int checks = 0;
  int errors = 0;

  mul32_shift_add dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .product      (product)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  task automatic check(input string tag, input logic [63:0] observed,
                       input logic [63:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Accept one operand pair at the next edge, confirm the 32-edge latency
  // and the product; optionally hand the result back to return to IDLE.
  task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                        input logic [63:0] expected, input string tag,
                        input bit hand_back);
    @(negedge clk);
    check({tag, "_in_ready_idle"}, 64'(in_ready), 64'd1);
    multiplicand = a;
    multiplier   = b;
    in_valid     = 1'b1;
    @(negedge clk);
    in_valid     = 1'b0;
    multiplicand = ~a;
    multiplier   = ~b;
    check({tag, "_in_ready_run"}, 64'(in_ready), 64'd0);
    repeat (31) @(negedge clk);
    check({tag, "_no_early_valid"}, 64'(out_valid), 64'd0);
    @(negedge clk);
    check({tag, "_out_valid"}, 64'(out_valid), 64'd1);
    check({tag, "_product"}, product, expected);
    if (hand_back) begin
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check({tag, "_back_to_idle"}, 64'(in_ready), 64'd1);
    end
  endtask

  initial begin
    bit seen_valid;

    rst_n        = 1'b0;
    in_valid     = 1'b0;
    out_ready    = 1'b0;
    multiplicand = '0;
    multiplier   = '0;

    #2;
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_product", product, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(32'd3, 32'd5, 64'h0000_0000_0000_000F, "small", 1'b1);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "max", 1'b1);
    run_op(32'h0000_0000, 32'hDEAD_BEEF, 64'h0, "zero", 1'b1);
    run_op(32'h0000_0001, 32'h8000_0000, 64'h0000_0000_8000_0000, "ident", 1'b1);
    run_op(32'hFFFF_FFFF, 32'h0000_0002, 64'h0000_0001_FFFF_FFFE, "carry", 1'b1);
    run_op(32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, "pow2", 1'b1);

    // Backpressure: result must stay put for 10 cycles without out_ready.
    run_op(32'd7, 32'd9, 64'd63, "bp", 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("bp_hold_valid", 64'(out_valid), 64'd1);
      check("bp_hold_product", product, 64'd63);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("bp_idle_in_ready", 64'(in_ready), 64'd1);
    check("bp_idle_out_valid", 64'(out_valid), 64'd0);
    check("bp_idle_product_held", product, 64'd63);

    // Busy: in_valid stays high with a new pair throughout the first run.
    @(negedge clk);
    multiplicand = 32'd11;
    multiplier   = 32'd13;
    in_valid     = 1'b1;
    @(negedge clk);
    multiplicand = 32'd100;
    multiplier   = 32'd200;
    check("busy_in_ready_run", 64'(in_ready), 64'd0);
    repeat (31) @(negedge clk);
    @(negedge clk);
    check("busy_first_valid", 64'(out_valid), 64'd1);
    check("busy_first_product", product, 64'd143);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("busy_idle_gap", 64'(in_ready), 64'd1);
    @(negedge clk);
    in_valid = 1'b0;
    check("busy_second_accepted", 64'(in_ready), 64'd0);
    repeat (31) @(negedge clk);
    @(negedge clk);
    check("busy_second_valid", 64'(out_valid), 64'd1);
    check("busy_second_product", product, 64'd20000);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;

    // Reset asserted at iteration 16 of a run, then an immediate new accept.
    @(negedge clk);
    multiplicand = 32'h1234_5678;
    multiplier   = 32'h1234_5678;
    in_valid     = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (16) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 64'(in_ready), 64'd1);
    check("midrst_out_valid", 64'(out_valid), 64'd0);
    check("midrst_product", product, 64'd0);
    seen_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      seen_valid |= out_valid;
    end
    rst_n        = 1'b1;
    multiplicand = 32'd2;
    multiplier   = 32'd3;
    in_valid     = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("postrst_first_edge_accept", 64'(in_ready), 64'd0);
    repeat (31) begin
      @(negedge clk);
      seen_valid |= out_valid;
    end
    check("midrst_no_valid_pulse", 64'(seen_valid), 64'd0);
    @(negedge clk);
    check("postrst_valid", 64'(out_valid), 64'd1);
    check("postrst_product", product, 64'd6);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("postrst_idle", 64'(in_ready), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
